// File: rtl/aes_spi_master_gen.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_master_gen
// Brief    : Mode-0 SPI master that ships {data_in,key} to an AES slave and
//            reads back the 128-bit result. Define AES_SPI_ABORT_EN for i_abort.
// Revision : 1.0
// ============================================================================
module aes_spi_master_gen #(
  parameter int NK        = 4,
  parameter int NUM_CS    = 2,
  parameter int CLK_DIV   = 1,
  parameter int WAIT_BITS = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_start,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] i_ch_sel,
  input  logic [127:0]                                  i_data_in,
  input  logic [NK*32-1:0]                              i_key,
`ifdef AES_SPI_ABORT_EN
  input  logic                                          i_abort,
`endif
  output logic                                          o_busy,
  output logic                                          o_done,
  output logic                                          o_err,
  output logic [127:0]                                  o_data_out,
  output logic                                          o_sclk,
  output logic                                          o_mosi,
  input  logic                                          i_miso,
  output logic [NUM_CS-1:0]                             o_cs_n
);

  localparam int c_TX_BITS = 128 + NK*32;
  localparam int c_BITS_W  = $clog2(c_TX_BITS + 1);
  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_GAP_W   = (WAIT_BITS > 0) ? $clog2(2*WAIT_BITS) : 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BITS_W-1:0] c_TX_LAST  = c_BITS_W'(c_TX_BITS - 1);
  localparam logic [c_BITS_W-1:0] c_RX_LAST  = c_BITS_W'(127);
  localparam logic [c_GAP_W-1:0]  c_GAP_LAST = c_GAP_W'((WAIT_BITS > 0) ? 2*WAIT_BITS - 1 : 0);
  localparam logic [NUM_CS-1:0]   c_CS_ONE   = NUM_CS'(1);

  generate
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_spi_master_gen: NK must be 4, 6 or 8");
    end
    if (NUM_CS < 1 || CLK_DIV < 1 || WAIT_BITS < 0) begin : g_bad_cfg
      $error("aes_spi_master_gen: NUM_CS/CLK_DIV must be >= 1, WAIT_BITS >= 0");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_TX     = 3'd2,
    S_GAP    = 3'd3,
    S_RX     = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                r_state;
  logic [c_DIV_W-1:0]    r_div;
  logic [c_BITS_W-1:0]   r_bits;
  logic [c_GAP_W-1:0]    r_gap;
  logic [c_TX_BITS-1:0]  r_tx;
  logic [127:0]          r_rx;
  logic [127:0]          r_data_out;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_sclk;
  logic                  r_mosi;
  logic [NUM_CS-1:0]     r_cs_n;

  logic w_tick;
  logic w_ch_ok;

  assign w_tick  = (r_div == c_DIV_LAST);
  assign w_ch_ok = (32'(i_ch_sel) < NUM_CS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bits     <= '0;
      r_gap      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= '1;
    end
`ifdef AES_SPI_ABORT_EN
    else if (i_abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bits  <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= '1;
    end
`endif
    else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // The divider free-runs through every timed phase; each wrap is one SCLK half-period.
      if (r_state == S_SETUP || r_state == S_TX || r_state == S_GAP || r_state == S_RX) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (i_start) begin
            if (w_ch_ok) begin
              r_tx    <= {i_data_in[126:0], i_key, 1'b0};
              r_mosi  <= i_data_in[127];
              r_cs_n  <= ~(c_CS_ONE << i_ch_sel);
              r_busy  <= 1'b1;
              r_div   <= '0;
              r_bits  <= '0;
              r_gap   <= '0;
              r_state <= S_SETUP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (w_tick) r_state <= S_TX;
        end
        S_TX: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              if (r_bits == c_TX_LAST) begin
                r_mosi  <= 1'b0;
                r_bits  <= '0;
                r_state <= (WAIT_BITS == 0) ? S_RX : S_GAP;
              end else begin
                r_mosi <= r_tx[c_TX_BITS-1];
                r_tx   <= {r_tx[c_TX_BITS-2:0], 1'b0};
                r_bits <= r_bits + 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_gap == c_GAP_LAST) begin
              r_gap   <= '0;
              r_state <= S_RX;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        S_RX: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              r_rx <= {r_rx[126:0], i_miso};
            end else if (r_bits == c_RX_LAST) begin
              r_bits  <= '0;
              r_state <= S_FINISH;
            end else begin
              r_bits <= r_bits + 1'b1;
            end
          end
        end
        S_FINISH: begin
          // busy stays up one more cycle; IDLE drops it unless a new start lands.
          r_cs_n     <= '1;
          r_data_out <= r_rx;
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_data_out = r_data_out;
  assign o_sclk     = r_sclk;
  assign o_mosi     = r_mosi;
  assign o_cs_n     = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_master_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_master_gen
// Brief    : Directed bench for aes_spi_master_gen (two configurations).
// Revision : 1.0
// ============================================================================
module tb_aes_spi_master_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Configuration A: NK=4, NUM_CS=2, CLK_DIV=1, WAIT_BITS=0
  logic         start_a, busy_a, done_a, err_a, sclk_a, mosi_a, miso_a;
  logic [0:0]   ch_a;
  logic [127:0] din_a, key_a, dout_a;
  logic [1:0]   csn_a;
  // Configuration B: NK=8, NUM_CS=3, CLK_DIV=3, WAIT_BITS=4
  logic         start_b, busy_b, done_b, err_b, sclk_b, mosi_b, miso_b;
  logic [1:0]   ch_b;
  logic [127:0] din_b, dout_b;
  logic [255:0] key_b;
  logic [2:0]   csn_b;
`ifdef AES_SPI_ABORT_EN
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
`endif

  aes_spi_master_gen #(.NK(4), .NUM_CS(2), .CLK_DIV(1), .WAIT_BITS(0)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_ch_sel(ch_a), .i_data_in(din_a),
    .i_key(key_a),
`ifdef AES_SPI_ABORT_EN
    .i_abort(abort_a),
`endif
    .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_data_out(dout_a),
    .o_sclk(sclk_a), .o_mosi(mosi_a), .i_miso(miso_a), .o_cs_n(csn_a)
  );

  aes_spi_master_gen #(.NK(8), .NUM_CS(3), .CLK_DIV(3), .WAIT_BITS(4)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_ch_sel(ch_b), .i_data_in(din_b),
    .i_key(key_b),
`ifdef AES_SPI_ABORT_EN
    .i_abort(abort_b),
`endif
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_data_out(dout_b),
    .o_sclk(sclk_b), .o_mosi(mosi_b), .i_miso(miso_b), .o_cs_n(csn_b)
  );

  // Slave models: capture mosi on SCLK rise, present response MSB first.
  int           cyc_n = 0, cnt_a = 0, cnt_b = 0, csbad_a = 0, csbad_b = 0;
  int           t_last_tx_b = 0, t_first_rx_b = 0;
  logic         prev_a = 1'b0, prev_b = 1'b0;
  logic [255:0] cap_a;
  logic [383:0] cap_b;
  logic [127:0] resp_a = '0, resp_b = '0, sh_a = '0, sh_b = '0;
  logic [1:0]   exp_cs_a = 2'b10;
  logic [2:0]   exp_cs_b = 3'b101;

  assign miso_a = sh_a[127];
  assign miso_b = sh_b[127];

  always @(negedge clk) begin
    cyc_n++;
    if (csn_a == 2'b11) begin
      cnt_a = 0;
      sh_a  = resp_a;
    end else begin
      if (csn_a != exp_cs_a) csbad_a++;
      if (sclk_a && !prev_a) begin
        if (cnt_a < 256) cap_a = {cap_a[254:0], mosi_a};
        else             sh_a  = {sh_a[126:0], 1'b0};
        cnt_a++;
      end
    end
    prev_a = sclk_a;
    if (csn_b == 3'b111) begin
      cnt_b = 0;
      sh_b  = resp_b;
    end else begin
      if (csn_b != exp_cs_b) csbad_b++;
      if (sclk_b && !prev_b) begin
        if (cnt_b == 383) t_last_tx_b  = cyc_n;
        if (cnt_b == 384) t_first_rx_b = cyc_n;
        if (cnt_b < 384) cap_b = {cap_b[382:0], mosi_b};
        else             sh_b  = {sh_b[126:0], 1'b0};
        cnt_b++;
      end
    end
    prev_b = sclk_b;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input int glitch, output int cyc);
    int errs;
    errs = 0;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("a_busy_on_accept", busy_a, 1'b1);
    check("a_cs_on_accept", csn_a, exp_cs_a);
    cyc = 0;
    while (!done_a && cyc < 5000) begin
      start_a = (cyc == glitch);
      if (cyc == glitch) begin
        din_a = ~din_a;
        key_a = ~key_a;
        ch_a  = ~ch_a;
      end
      @(posedge clk); #1;
      cyc++;
      if (err_a) errs++;
    end
    start_a = 1'b0;
    check("a_no_err_while_busy", errs, 0);
  endtask

  task automatic run_b(output int cyc);
    @(posedge clk); #1;
    start_b = 1'b0;
    check("b_busy_on_accept", busy_b, 1'b1);
    cyc = 0;
    while (!done_b && cyc < 10000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    logic [255:0] exp_a;
    logic [383:0] exp_b;
    logic [127:0] prev_resp;
    int cyc, k, seen, base;

    rst = 1'b0;
    start_a = 1'b0; ch_a = '0; din_a = '0; key_a = '0;
    start_b = 1'b0; ch_b = '0; din_b = '0; key_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_err_a", err_a, 1'b0);
    check("rst_dout_a", dout_a, 128'h0);
    check("rst_sclk_a", sclk_a, 1'b0);
    check("rst_mosi_a", mosi_a, 1'b0);
    check("rst_csn_a", csn_a, 2'b11);
    check("rst_csn_b", csn_b, 3'b111);
    check("rst_busy_b", busy_b, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // A1: FIPS-197 AES-128 example frame on channel 0
    din_a  = 128'h00112233445566778899aabbccddeeff;
    key_a  = 128'h000102030405060708090a0b0c0d0e0f;
    resp_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp_a  = {din_a, key_a};
    exp_cs_a = 2'b10; ch_a = 1'b0; base = csbad_a;
    start_a = 1'b1;
    run_a(-1, cyc);
    check("a1_done_cycle", cyc, 770);
    check("a1_data_out", dout_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("a1_mosi_stream", cap_a, exp_a);
    check("a1_cs_held", csbad_a - base, 0);
    check("a1_cs_release", csn_a, 2'b11);
    @(posedge clk); #1;
    check("a1_done_one_cycle", done_a, 1'b0);
    check("a1_busy_clear", busy_a, 1'b0);

    // A2: start re-pulsed mid-TX with different inputs must be ignored
    din_a  = 128'hfedcba98765432100123456789abcdef;
    key_a  = 128'h0f0e0d0c0b0a09080706050403020100;
    resp_a = 128'ha5a5a5a5_0000ffff_12345678_c3c3c3c3;
    exp_a  = {din_a, key_a};
    ch_a = 1'b0; base = csbad_a;
    start_a = 1'b1;
    run_a(100, cyc);
    check("a2_done_cycle", cyc, 770);
    check("a2_mosi_stream", cap_a, exp_a);
    check("a2_data_out", dout_a, 128'ha5a5a5a5_0000ffff_12345678_c3c3c3c3);
    check("a2_cs_held", csbad_a - base, 0);
    @(posedge clk); #1;

    // B1: NK=8, CLK_DIV=3, WAIT_BITS=4 on channel 1
    din_b  = 128'h00112233445566778899aabbccddeeff;
    key_b  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    resp_b = 128'h8ea2b7ca516745bfeafc49904b496089;
    exp_b  = {din_b, key_b};
    exp_cs_b = 3'b101; ch_b = 2'd1; base = csbad_b;
    start_b = 1'b1;
    run_b(cyc);
    check("b1_done_cycle", cyc, 3100);
    check("b1_data_out", dout_b, 128'h8ea2b7ca516745bfeafc49904b496089);
    check("b1_mosi_stream", cap_b, exp_b);
    check("b1_cs_held", csbad_b - base, 0);
    check("b1_gap_rise_spacing", t_first_rx_b - t_last_tx_b, 30);
    @(posedge clk); #1;
    check("b1_busy_clear", busy_b, 1'b0);

    // B2: out-of-range channel is rejected with a single err pulse
    ch_b = 2'd3;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("b2_err_pulse", err_b, 1'b1);
    check("b2_busy_low", busy_b, 1'b0);
    check("b2_cs_idle", csn_b, 3'b111);
    @(posedge clk); #1;
    check("b2_err_one_cycle", err_b, 1'b0);
    check("b2_busy_still_low", busy_b, 1'b0);

`ifdef AES_SPI_ABORT_EN
    // B3: abort inside the TX/RX gap, then a clean frame
    prev_resp = resp_b;
    resp_b = 128'h0123456789abcdeffedcba9876543210;
    ch_b = 2'd1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    k = 0;
    while (cnt_b < 384 && k < 4000) begin
      @(posedge clk); #1;
      k++;
    end
    check("b3_reach_gap", cnt_b, 384);
    repeat (8) @(posedge clk);
    #1;
    abort_b = 1'b1;
    @(posedge clk); #1;
    abort_b = 1'b0;
    check("b3_abort_busy", busy_b, 1'b0);
    check("b3_abort_cs", csn_b, 3'b111);
    check("b3_abort_sclk", sclk_b, 1'b0);
    check("b3_abort_mosi", mosi_b, 1'b0);
    check("b3_abort_dout_kept", dout_b, prev_resp);
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done_b) seen++;
    end
    check("b3_abort_no_done", seen, 0);
    start_b = 1'b1;
    run_b(cyc);
    check("b3_after_abort_done_cycle", cyc, 3100);
    check("b3_after_abort_dout", dout_b, 128'h0123456789abcdeffedcba9876543210);
    @(posedge clk); #1;
`endif

    // A3: reset during RX aborts with no done and clears data_out
    ch_a = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    k = 0;
    while (cnt_a < 306 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("a3_reach_rx_bit50", cnt_a, 306);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("a3_rst_cs", csn_a, 2'b11);
    check("a3_rst_sclk", sclk_a, 1'b0);
    check("a3_rst_busy", busy_a, 1'b0);
    check("a3_rst_dout", dout_a, 128'h0);
    seen = 0;
    repeat (800) begin
      @(posedge clk); #1;
      if (done_a) seen++;
    end
    check("a3_rst_no_done", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_spi_master_gen.md
Name: aes_spi_master_gen

Overview:
- Parametrised SPI master feeding AES cipher/inverse-cipher slaves.
- Serialises {data_in, key} (128 + NK*32 bits, MSB first) to the channel selected at start, waits a programmable gap, then shifts back the 128-bit result.
- Generated SCLK (mode 0) with a divider; explicit start/busy/done handshake; one-hot active-low chip selects over NUM_CS channels.
- Sits between the AES top-level controller and the SPI_Slave instances.

Parameters:
- NK, 4, key words (legal 4/6/8; anything else is an elaboration error); TX_BITS = 128+NK*32.
- NUM_CS, 2, number of slave channels (ch 0 = encrypt, ch 1 = decrypt by convention); minimum 1.
- CLK_DIV, 1, clk cycles per SCLK half-period; minimum 1.
- WAIT_BITS, 0, idle SCLK periods between the TX and RX phases; 0 allowed.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- ch_sel  in  max(1,$clog2(NUM_CS))  target channel, latched with start.
- data_in  in  128  plaintext/ciphertext block, latched with start.
- key  in  NK*32  cipher key, latched with start.
- busy  out  1  high from the cycle after accepted start until the cycle after done.
- done  out  1  one-cycle pulse; data_out valid.
- err  out  1  one-cycle pulse; start rejected because ch_sel >= NUM_CS.
- data_out  out  128  last received block; holds until the next done.
- sclk  out  1  SPI clock; idle low.
- mosi  out  1  serial out; changes on SCLK falling edge or CS assertion.
- miso  in  1  serial in; sampled on SCLK rising edge.
- cs_n  out  NUM_CS  active-low selects; at most one low.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; busy=0, done=0, err=0, data_out=0, sclk=0, mosi=0, cs_n all 1, counters 0. Reset mid-transfer aborts immediately; no done is issued.
- IDLE: if start=1 and ch_sel<NUM_CS, latch tx shift register {data_in,key}, drive cs_n[ch_sel]=0, mosi=tx MSB, busy=1, go SETUP. If start=1 and ch_sel invalid, pulse err, stay IDLE, outputs unchanged.
- SETUP: hold sclk low for CLK_DIV cycles (CS-to-SCLK setup), then go TX.
- TX: sclk toggles every CLK_DIV cycles. Each falling edge shifts the next bit onto mosi. After TX_BITS full SCLK periods (ending on a falling edge), mosi=0 and go GAP (or RX if WAIT_BITS=0).
- GAP: sclk low, cs_n held, for 2*CLK_DIV*WAIT_BITS cycles, then go RX.
- RX: 128 SCLK periods. Each rising edge shifts miso into the rx register LSB side (first bit ends at bit 127).
- FINISH: entered after the last falling edge. In that cycle: cs_n all 1, data_out<=rx register, done=1. Next cycle: busy=0, state IDLE, and a new start may be accepted in that same cycle.
- Latency: start is sampled at edge 0. done is high in cycle 1 + CLK_DIV*(1 + 2*(TX_BITS + WAIT_BITS + 128)). For NK=4, CLK_DIV=1, WAIT_BITS=0 this is cycle 770.
- start while busy is ignored (no err). Input changes after acceptance have no effect.
- Bit counter width: $clog2(TX_BITS+1). Divider counter wraps at CLK_DIV-1.

Optional Feature:
- Macro AES_SPI_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in any non-IDLE state causes, at the next posedge: cs_n all 1, sclk 0, mosi 0, busy 0, state IDLE. No done is issued and data_out is unchanged. abort in IDLE has no effect. Reset has priority over abort.
- Undefined: no port and no abort logic.

Test Plan:
- NK=4, CLK_DIV=1: start with ch_sel=0, data_in=128'h00112233445566778899aabbccddeeff, key=128'h000102030405060708090a0b0c0d0e0f, slave model returns 128'h69c4e0d86a7b0430d8cdb78070b4c55a -> mosi stream equals {data_in,key} MSB first, cs_n=2'b10 throughout, done at cycle 770, data_out=69c4…c55a.
- NK=8, CLK_DIV=3, WAIT_BITS=4, ch_sel=1 -> cs_n=2'b01, 384 TX periods, 24-cycle gap with sclk low, done at cycle 1+3*(1+2*516)=3100.
- start with ch_sel=2 (NUM_CS=2) -> err pulses 1 cycle, cs_n stays 2'b11, busy stays 0.
- start pulsed again mid-TX with different data -> ignored; original frame completes unchanged.
- rst=0 during RX bit 50 -> next posedge: cs_n all 1, sclk 0, busy 0, data_out=0, no done pulse.
- With AES_SPI_ABORT_EN: abort during GAP -> next cycle IDLE, cs_n all 1, data_out keeps previous value; a following start completes normally.
